// File: rtl/mux16_arbiter.sv
// mux16_arbiter: round-robin owner of one shared 16-bit bus for requesters A and B, with bounded hold.
// Optional feature MUX16_ARB_LOCK_EN adds a `lock` input that lets the current owner suppress preemption.

module mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);
    assign out = sel ? b : a;
endmodule

// state  | meaning
// IDLE   | nobody owns the bus; sel keeps its last value
// OWN_A  | A owns the bus, hold_cnt counts its cycles
// OWN_B  | B owns the bus, hold_cnt counts its cycles
module mux16_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic        req_b,
`ifdef MUX16_ARB_LOCK_EN
    input  logic        lock,
`endif
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        sel,
    output logic [15:0] bus_out,
    output logic        bus_valid
);
    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    state_t          state_q, state_d;
    owner_t          last_owner_q, last_owner_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            sel_q, sel_d;
    logic            gnt_a_q, gnt_a_d;
    logic            gnt_b_q, gnt_b_d;
    logic [15:0]     bus_out_q, bus_out_d;
    logic            bus_valid_q, bus_valid_d;
    logic [15:0]     mux_out;
    logic            hold_sat;
    logic            lock_eff;
    logic            own_req;

`ifdef MUX16_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    assign hold_sat = (hold_cnt_q == HOLD_LAST);

    mux16 u_mux16 (
        .a   (data_a),
        .b   (data_b),
        .sel (sel_q),
        .out (mux_out)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        sel_d        = sel_q;

        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_owner_q == OWNER_A) ? OWN_B : OWN_A;
                end else if (req_a) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end else if (req_b && hold_sat && !lock_eff) begin
                    state_d = OWN_B;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end else if (req_a && hold_sat && !lock_eff) begin
                    state_d = OWN_A;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh owner restarts its hold window; a continuing owner counts up and saturates.
        if ((state_d != state_q) && (state_d != IDLE)) begin
            hold_cnt_d   = '0;
            last_owner_d = (state_d == OWN_B) ? OWNER_B : OWNER_A;
            sel_d        = (state_d == OWN_B);
        end else if ((state_d != IDLE) && !hold_sat) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_comb begin
        gnt_a_d     = (state_d == OWN_A);
        gnt_b_d     = (state_d == OWN_B);
        own_req     = (gnt_a_q & req_a) | (gnt_b_q & req_b);
        bus_valid_d = own_req;
        bus_out_d   = own_req ? mux_out : bus_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_B;
            hold_cnt_q   <= '0;
            sel_q        <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            bus_out_q    <= 16'h0000;
            bus_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            sel_q        <= sel_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            bus_out_q    <= bus_out_d;
            bus_valid_q  <= bus_valid_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign sel       = sel_q;
    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_mux16_arbiter.sv
// tb_mux16_arbiter: directed scenarios plus random contention, checked every cycle against a bus-ownership model.

module tb_mux16_arbiter;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] data_a = 16'h0000;
    logic [15:0] data_b = 16'h0000;
    logic        gnt_a, gnt_b, sel, bus_valid;
    logic [15:0] bus_out;
`ifdef MUX16_ARB_LOCK_EN
    logic        lock = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux16_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef MUX16_ARB_LOCK_EN
        .lock      (lock),
`endif
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: owner 0 = nobody, 1 = A, 2 = B; m_cnt = cycles the owner has held so far.
    int          m_owner = 0;
    int          m_cnt   = 0;
    int          m_last  = 2;
    int          m_nxt;
    bit          m_mine, m_other;
    bit          m_sel   = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] m_bus   = 16'h0000;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = 0; m_cnt = 0; m_last = 2;
            m_sel = 1'b0; m_valid = 1'b0; m_bus = 16'h0000;
        end else begin
            m_valid = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
            if (m_valid) m_bus = (m_owner == 1) ? data_a : data_b;
            m_nxt = m_owner;
            if (m_owner == 0) begin
                if (req_a && req_b) m_nxt = 3 - m_last;
                else if (req_a)     m_nxt = 1;
                else if (req_b)     m_nxt = 2;
            end else begin
                m_mine  = (m_owner == 1) ? req_a : req_b;
                m_other = (m_owner == 1) ? req_b : req_a;
                if (!m_mine)                          m_nxt = m_other ? 3 - m_owner : 0;
                else if (m_other && m_cnt >= MAX_HOLD) m_nxt = 3 - m_owner;
            end
            if (m_nxt != 0 && m_nxt != m_owner) begin
                m_cnt = 1; m_last = m_nxt; m_sel = (m_nxt == 2);
            end else if (m_nxt != 0 && m_cnt < 1000) begin
                m_cnt++;
            end
            m_owner = m_nxt;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check1("gnt_a", gnt_a, m_owner == 1);
            check1("gnt_b", gnt_b, m_owner == 2);
            check1("sel", sel, m_sel);
            check1("bus_valid", bus_valid, m_valid);
            check16("bus_out", bus_out, m_bus);
            check1("grant_exclusive", gnt_a & gnt_b, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic ga [12];
    logic gb [12];
    int   wait_cnt;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check1("rst_gnt_a", gnt_a, 1'b0);
        check1("rst_gnt_b", gnt_b, 1'b0);
        check1("rst_sel", sel, 1'b0);
        check1("rst_bus_valid", bus_valid, 1'b0);
        check16("rst_bus_out", bus_out, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_en = 1'b1;

        // A alone: grant one edge after request, data one edge later.
        step();
        req_a = 1'b1; data_a = 16'h1234;
        step();
        check1("t1_gnt_a", gnt_a, 1'b1);
        check1("t1_sel", sel, 1'b0);
        check1("t1_valid_early", bus_valid, 1'b0);
        step();
        check16("t1_bus_out", bus_out, 16'h1234);
        check1("t1_valid", bus_valid, 1'b1);

        // Release, then contention from IDLE: A owned last, so B goes first, 4-cycle turns.
        req_a = 1'b0;
        step();
        step();
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            ga[i] = gnt_a;
            gb[i] = gnt_b;
        end
        for (int i = 0; i < 12; i++) begin
            check1("t2_gnt_b_turn", gb[i], (i < 4) || (i >= 8));
            check1("t2_gnt_a_turn", ga[i], (i >= 4) && (i < 8));
        end

        // Handover on release: A drops as B rises.
        req_b = 1'b0;
        wait_cnt = 0;
        while (!gnt_a && wait_cnt < 10) begin
            step();
            wait_cnt++;
        end
        check1("t3_wait_gnt_a", gnt_a, 1'b1);
        req_a = 1'b0; req_b = 1'b1; data_b = 16'hBEEF;
        step();
        check1("t3_gnt_b", gnt_b, 1'b1);
        check1("t3_sel", sel, 1'b1);
        step();
        check16("t3_bus_out", bus_out, 16'hBEEF);

        // B alone for 10 cycles keeps the bus.
        for (int i = 0; i < 10; i++) begin
            data_b = 16'(i);
            step();
            check1("t4_gnt_b_held", gnt_b, 1'b1);
        end
        check1("t4_valid", bus_valid, 1'b1);

        // Asynchronous reset mid-ownership, then tie after release goes to A.
        #1 rst_n = 1'b0;
        #1;
        check1("t5_gnt_b", gnt_b, 1'b0);
        check1("t5_valid", bus_valid, 1'b0);
        check16("t5_bus_out", bus_out, 16'h0000);
        check1("t5_sel", sel, 1'b0);
        req_a = 1'b1; req_b = 1'b1;
        #2 rst_n = 1'b1;
        step();
        check1("t5_gnt_a_first", gnt_a, 1'b1);
        check1("t5_gnt_b_low", gnt_b, 1'b0);

        // Random traffic: sticky requests with occasional toggles, fresh data each cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            data_a = 16'($urandom);
            data_b = 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
